// File: rtl/keycode_report_rx.sv
`default_nettype none
// ============================================================================
//  Module      : keycode_report_rx
//  Description : Receives 8-byte HID boot-keyboard reports and compacts them.
//                Reports are published once per synchronized frame_tick edge.
//                Optional build macro: KEYCODE_ROLLOVER_HOLD_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module keycode_report_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] rpt_byte,
  input  logic       rpt_valid,
  input  logic       rpt_sop,
  output logic       rpt_ready,
  input  logic       frame_tick,
  output logic [7:0] keycode0,
  output logic [7:0] keycode1,
  output logic [7:0] keycode2,
  output logic [7:0] keycode3,
  output logic [7:0] modifier,
  output logic       keycode_valid,
  output logic       rollover_err,
  output logic [7:0] sync_err_cnt
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                 r_state;
  logic                   r_ready;
  logic [2:0]             r_idx;
  logic [7:0]             r_stg_mod;
  logic [7:0]             r_stg_key [0:5];

  logic                   r_pend_full;
  logic [7:0]             r_pend_mod;
  logic [7:0]             r_pend_key [0:3];
  logic                   r_pend_roll;

  logic [7:0]             r_out_mod;
  logic [7:0]             r_out_key [0:3];
  logic                   r_out_valid;
  logic                   r_out_roll;
  logic [7:0]             r_err_cnt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_q;

  logic                   w_xfer;
  logic                   w_pub;
  logic                   w_commit;
  logic                   w_pend_free;
  logic                   w_load;
  logic                   w_err;
  logic                   w_roll;
  logic [2:0]             w_cnt;
  logic [7:0]             w_b       [0:5];
  logic [7:0]             w_cmp     [0:3];
  logic [7:0]             w_new_key [0:3];

  // frame_tick is asynchronous; only the synchronized rising edge publishes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync   <= '0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], frame_tick};
      r_sync_q <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_pub       = r_sync[SYNC_STAGES-1] & ~r_sync_q;
  assign w_xfer      = rpt_valid & r_ready;
  assign w_commit    = w_xfer & ~rpt_sop & (r_idx == 3'd7);
  assign w_pend_free = ~r_pend_full | w_pub;
  assign w_load      = (r_state == COLLECT) ? (w_commit & w_pend_free) : w_pub;
  assign w_err       = w_xfer & ((rpt_sop & (r_idx != 3'd0)) |
                                 (~rpt_sop & (r_idx == 3'd0)));

  // Byte 7 comes straight off the bus while collecting, from staging in HOLD
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_b[i] = r_stg_key[i];
    end
    w_b[5] = (r_state == HOLD) ? r_stg_key[5] : rpt_byte;
  end

  always_comb begin
    w_roll = 1'b1;
    w_cnt  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_cmp[i] = 8'h00;
    end
    for (int i = 0; i < 6; i++) begin
      if (w_b[i] != 8'h01) begin
        w_roll = 1'b0;
      end
      if (w_b[i] != 8'h00) begin
        if (w_cnt < 3'd4) begin
          w_cmp[w_cnt[1:0]] = w_b[i];
        end
        w_cnt = w_cnt + 3'd1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      w_new_key[i] = w_roll ? 8'h00 : w_cmp[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= COLLECT;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_commit && !w_pend_free) begin
            r_state <= HOLD;
            r_ready <= 1'b0;
          end
        end
        HOLD: begin
          if (w_pub) begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= COLLECT;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx       <= 3'd0;
      r_stg_mod   <= 8'h00;
      r_pend_full <= 1'b0;
      r_pend_mod  <= 8'h00;
      r_pend_roll <= 1'b0;
      r_out_mod   <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_roll  <= 1'b0;
      r_err_cnt   <= 8'h00;
      for (int i = 0; i < 6; i++) begin
        r_stg_key[i] <= 8'h00;
      end
      for (int i = 0; i < 4; i++) begin
        r_pend_key[i] <= 8'h00;
        r_out_key[i]  <= 8'h00;
      end
    end else begin
      if (w_pub && r_pend_full) begin
        r_out_mod   <= r_pend_mod;
        r_out_roll  <= r_pend_roll;
        r_out_valid <= 1'b1;
`ifdef KEYCODE_ROLLOVER_HOLD_EN
        if (!r_pend_roll) begin
          for (int i = 0; i < 4; i++) begin
            r_out_key[i] <= r_pend_key[i];
          end
        end
`else
        for (int i = 0; i < 4; i++) begin
          r_out_key[i] <= r_pend_key[i];
        end
`endif
      end

      // A commit coinciding with a publish refills the slot being vacated
      if (w_load) begin
        r_pend_full <= 1'b1;
        r_pend_mod  <= r_stg_mod;
        r_pend_roll <= w_roll;
        for (int i = 0; i < 4; i++) begin
          r_pend_key[i] <= w_new_key[i];
        end
      end else if (w_pub) begin
        r_pend_full <= 1'b0;
      end

      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      if (w_xfer) begin
        if (rpt_sop) begin
          r_stg_mod <= rpt_byte;
          r_idx     <= 3'd1;
        end else if (r_idx != 3'd0) begin
          if (r_idx >= 3'd2) begin
            r_stg_key[r_idx - 3'd2] <= rpt_byte;
          end
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign rpt_ready     = r_ready;
  assign keycode0      = r_out_key[0];
  assign keycode1      = r_out_key[1];
  assign keycode2      = r_out_key[2];
  assign keycode3      = r_out_key[3];
  assign modifier      = r_out_mod;
  assign keycode_valid = r_out_valid;
  assign rollover_err  = r_out_roll;
  assign sync_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_keycode_report_rx.sv
`default_nettype none
// Directed bench for keycode_report_rx with a queue of expected publications.
module tb_keycode_report_rx;

  localparam int SYNC = 2;
`ifdef KEYCODE_ROLLOVER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] rpt_byte;
  logic       rpt_valid;
  logic       rpt_sop;
  logic       rpt_ready;
  logic       frame_tick;
  logic [7:0] keycode0, keycode1, keycode2, keycode3, modifier, sync_err_cnt;
  logic       keycode_valid, rollover_err;

  keycode_report_rx #(.SYNC_STAGES(SYNC)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .rpt_byte(rpt_byte), .rpt_valid(rpt_valid), .rpt_sop(rpt_sop),
    .rpt_ready(rpt_ready), .frame_tick(frame_tick),
    .keycode0(keycode0), .keycode1(keycode1), .keycode2(keycode2),
    .keycode3(keycode3), .modifier(modifier),
    .keycode_valid(keycode_valid), .rollover_err(rollover_err),
    .sync_err_cnt(sync_err_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] mod, k0, k1, k2, k3;
    logic       roll;
    logic       valid;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       m_out;
  int         m_err;
  int         n_pass;
  int         n_total;
  int         n_fail;
  logic [7:0] rpt [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_rpt();
    exp_t       e;
    logic [7:0] k [0:3];
    int         n;
    bit         roll;
    n    = 0;
    roll = 1'b1;
    for (int i = 0; i < 4; i++) k[i] = 8'h00;
    for (int i = 2; i < 8; i++) begin
      if (rpt[i] != 8'h01) roll = 1'b0;
      if (rpt[i] != 8'h00) begin
        if (n < 4) k[n] = rpt[i];
        n++;
      end
    end
    if (roll) for (int i = 0; i < 4; i++) k[i] = 8'h00;
    e.mod = rpt[0]; e.k0 = k[0]; e.k1 = k[1]; e.k2 = k[2]; e.k3 = k[3];
    e.roll = roll; e.valid = 1'b1;
    return e;
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, "_k0"},    keycode0,      m_out.k0);
    check({tag, "_k1"},    keycode1,      m_out.k1);
    check({tag, "_k2"},    keycode2,      m_out.k2);
    check({tag, "_k3"},    keycode3,      m_out.k3);
    check({tag, "_mod"},   modifier,      m_out.mod);
    check({tag, "_valid"}, keycode_valid, m_out.valid);
    check({tag, "_roll"},  rollover_err,  m_out.roll);
    check({tag, "_errc"},  sync_err_cnt,  m_err[7:0]);
    check({tag, "_ready"}, rpt_ready,     1'b1);
  endtask

  // Starts and ends at a falling edge; the byte moves on the rising edge between.
  task automatic send_byte(input logic [7:0] b, input logic sop);
    int n;
    n = 0;
    rpt_byte = b; rpt_valid = 1'b1; rpt_sop = sop;
    while (!rpt_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!rpt_ready) check("ready_timeout", rpt_ready, 1'b1);
    @(negedge Clk);
    rpt_valid = 1'b0; rpt_sop = 1'b0;
  endtask

  task automatic send_report();
    exp_q.push_back(model_rpt());
    for (int i = 0; i < 8; i++) send_byte(rpt[i], (i == 0));
  endtask

  task automatic do_tick(input string tag);
    exp_t e;
    frame_tick = 1'b1;
    repeat (SYNC + 3) @(negedge Clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_out.mod   = e.mod;
      m_out.roll  = e.roll;
      m_out.valid = 1'b1;
      if (!(e.roll && HOLD_EN)) begin
        m_out.k0 = e.k0; m_out.k1 = e.k1; m_out.k2 = e.k2; m_out.k3 = e.k3;
      end
    end
    compare_outputs(tag);
    frame_tick = 1'b0;
    repeat (SYNC + 2) @(negedge Clk);
  endtask

  task automatic clear_model();
    m_out = '{mod: 8'h00, k0: 8'h00, k1: 8'h00, k2: 8'h00, k3: 8'h00, roll: 1'b0, valid: 1'b0};
    m_err = 0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    clear_model();
    Reset_n = 1'b0; rpt_byte = 8'h00; rpt_valid = 1'b0; rpt_sop = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge Clk);
    compare_outputs("reset");
    Reset_n = 1'b1;
    @(negedge Clk);
    check("ready_after_reset", rpt_ready, 1'b1);

    // Basic report
    rpt = '{8'h02, 8'h00, 8'h00, 8'h04, 8'h00, 8'h1A, 8'h2C, 8'h00};
    send_report();
    do_tick("basic");
    check("basic_k0_const", keycode0, 8'h04);
    check("basic_k1_const", keycode1, 8'h1A);
    check("basic_k2_const", keycode2, 8'h2C);
    check("basic_mod_const", modifier, 8'h02);

    // Pending plus staging, then HOLD back-pressure
    rpt = '{8'h01, 8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_report();
    rpt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0B};
    send_report();
    check("hold_ready_low", rpt_ready, 1'b0);
    do_tick("two_rpt");
    rpt = '{8'h20, 8'h00, 8'h1E, 8'h00, 8'h1F, 8'h00, 8'h20, 8'h00};
    send_report();
    check("third_ready_low", rpt_ready, 1'b0);
    repeat (6) @(negedge Clk);
    check("third_ready_stays_low", rpt_ready, 1'b0);
    do_tick("second_pub");
    do_tick("third_pub");
    do_tick("empty_tick");

    // Mid-report sop resynchronises
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rpt = '{8'h08, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(model_rpt());
    send_byte(rpt[0], 1'b1);
    m_err++;
    for (int i = 1; i < 8; i++) send_byte(rpt[i], 1'b0);
    check("resync_errc", sync_err_cnt, 8'd1);
    do_tick("resync");

    // Stray byte without sop at index 0 is dropped
    send_byte(8'h55, 1'b0);
    m_err++;
    check("stray_errc", sync_err_cnt, 8'd2);
    rpt = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3D};
    send_report();
    do_tick("after_stray");

    // Rollover handling
    rpt = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report();
    do_tick("pre_roll");
    rpt = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_report();
    do_tick("roll");
    check("roll_flag", rollover_err, 1'b1);
    check("roll_k0", keycode0, HOLD_EN ? 8'h04 : 8'h00);
    rpt = '{8'h40, 8'h00, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report();
    do_tick("post_roll");
    check("post_roll_flag", rollover_err, 1'b0);

    // Commit on the same cycle as a publish edge with pending empty
    rpt = '{8'h04, 8'h00, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h16};
    for (int i = 0; i < 7; i++) send_byte(rpt[i], (i == 0));
    frame_tick = 1'b1;
    repeat (SYNC) @(negedge Clk);
    rpt_byte = rpt[7]; rpt_valid = 1'b1; rpt_sop = 1'b0;
    check("coinc_ready", rpt_ready, 1'b1);
    @(negedge Clk);
    rpt_valid = 1'b0;
    repeat (2) @(negedge Clk);
    compare_outputs("coinc_nochange");
    frame_tick = 1'b0;
    repeat (SYNC + 2) @(negedge Clk);
    exp_q.push_back(model_rpt());
    do_tick("coinc_next");

    // Reset in the middle of a report
    rpt = '{8'h01, 8'h00, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) send_byte(rpt[i], (i == 0));
    Reset_n = 1'b0;
    clear_model();
    @(negedge Clk);
    compare_outputs("mid_reset");
    Reset_n = 1'b1;
    @(negedge Clk);
    rpt = '{8'h03, 8'h00, 8'h00, 8'h27, 8'h00, 8'h00, 8'h28, 8'h00};
    send_report();
    do_tick("after_reset");
    check("after_reset_k0_const", keycode0, 8'h27);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
